// File: rtl/acc_bias_gen_pkg.sv
// Shared definitions for the acc+bias producer and the bound stage:
// FSM encoding, saturation limits and lane pack/unpack helpers.
`ifndef ACC_BIAS_GEN_LANE_MACROS
`define ACC_BIAS_GEN_LANE_MACROS
`define ABG_LANE(vec, idx, bw) vec[(idx)*(bw) +: (bw)]
`endif

package acc_bias_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    function automatic longint sat_max(input int unsigned bw);
        return (64'sd1 <<< (bw - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_min(input int unsigned bw);
        return -(64'sd1 <<< (bw - 1));
    endfunction

endpackage

// File: rtl/acc_bias_gen_col.sv
// One column: accumulator register with bias load and saturating add,
// plus a sticky saturation flag cleared on every bias load.
module acc_sat_col
    import acc_bias_gen_pkg::*;
#(
    parameter int PS_BW   = 16,
    parameter int BIAS_BW = 16,
    parameter int AB_BW   = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load_i,
    input  logic               add_i,
    input  logic [BIAS_BW-1:0] bias_i,
    input  logic [PS_BW-1:0]   ps_i,
    output logic [AB_BW-1:0]   acc_o,
    output logic               sat_o
);

    localparam int SUM_W = AB_BW + 1;
    localparam logic signed [SUM_W-1:0] SUM_MAX = SUM_W'(sat_max(AB_BW));
    localparam logic signed [SUM_W-1:0] SUM_MIN = SUM_W'(sat_min(AB_BW));
    localparam logic [AB_BW-1:0] ACC_MAX = SUM_MAX[AB_BW-1:0];
    localparam logic [AB_BW-1:0] ACC_MIN = SUM_MIN[AB_BW-1:0];

    logic [AB_BW-1:0]        acc_q, acc_d;
    logic                    sat_q, sat_d;
    logic [SUM_W-1:0]        acc_ext, ps_ext;
    logic signed [SUM_W-1:0] sum;

    // One extra bit of headroom makes overflow detection a plain signed compare.
    always_comb begin
        acc_ext = {{(SUM_W - AB_BW){acc_q[AB_BW-1]}}, acc_q};
        ps_ext  = {{(SUM_W - PS_BW){ps_i[PS_BW-1]}}, ps_i};
        sum     = $signed(acc_ext) + $signed(ps_ext);
    end

    always_comb begin
        acc_d = acc_q;
        sat_d = sat_q;
        if (load_i) begin
            acc_d = {{(AB_BW - BIAS_BW){bias_i[BIAS_BW-1]}}, bias_i};
            sat_d = 1'b0;
        end else if (add_i) begin
            if (sum > SUM_MAX) begin
                acc_d = ACC_MAX;
                sat_d = 1'b1;
            end else if (sum < SUM_MIN) begin
                acc_d = ACC_MIN;
                sat_d = 1'b1;
            end else begin
                acc_d = sum[AB_BW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q <= '0;
            sat_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
        end
    end

    assign acc_o = acc_q;
    assign sat_o = sat_q;

endmodule

// File: rtl/acc_bias_gen.sv
// Per-tile bias + partial-sum accumulator across COLS columns; emits one
// saturated packed result per tile over a valid/ready handshake.
module acc_bias_gen
    import acc_bias_gen_pkg::*;
#(
    parameter int COLS    = 5,
    parameter int PS_BW   = 16,
    parameter int BIAS_BW = 16,
    parameter int AB_BW   = 25,
    parameter int CNT_BW  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_start,
    input  logic [CNT_BW-1:0]       i_k_len,
    input  logic [BIAS_BW*COLS-1:0] i_bias,
    input  logic                    i_ps_valid,
    output logic                    o_ps_ready,
    input  logic [PS_BW*COLS-1:0]   i_ps,
    output logic                    o_busy,
    output logic                    o_acc_valid,
    input  logic                    i_out_ready,
    output logic [AB_BW*COLS-1:0]   o_acc_bias,
    output logic [COLS-1:0]         o_sat
);

    localparam logic [CNT_BW-1:0] CNT_ONE = CNT_BW'(1);

    state_e            state_q, state_d;
    logic [CNT_BW-1:0] cnt_q, cnt_d;
    logic [CNT_BW-1:0] len_q, len_d;
    logic              valid_q, valid_d;
    logic              accept, take, load, add;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        load    = 1'b0;
        add     = 1'b0;
        accept  = (state_q == ST_HOLD) && valid_q && i_out_ready;
        take    = i_start && ((state_q == ST_IDLE) || accept);

        case (state_q)
            ST_ACCUM: begin
                if (i_ps_valid) begin
                    add   = 1'b1;
                    cnt_d = cnt_q + CNT_ONE;
                    if (cnt_q == len_q - CNT_ONE) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (take) begin
            load    = 1'b1;
            cnt_d   = '0;
            len_d   = i_k_len;
            state_d = (i_k_len != '0) ? ST_ACCUM : ST_HOLD;
        end

        // Valid is its own register so a back-to-back zero-length tile, which
        // stays in HOLD, still shows a one-cycle gap before its result.
        valid_d = (state_d == ST_HOLD) && !accept;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            valid_q <= valid_d;
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        acc_sat_col #(
            .PS_BW   (PS_BW),
            .BIAS_BW (BIAS_BW),
            .AB_BW   (AB_BW)
        ) u_col (
            .clk    (clk),
            .rst_n  (rst_n),
            .load_i (load),
            .add_i  (add),
            .bias_i (`ABG_LANE(i_bias, c, BIAS_BW)),
            .ps_i   (`ABG_LANE(i_ps, c, PS_BW)),
            .acc_o  (`ABG_LANE(o_acc_bias, c, AB_BW)),
            .sat_o  (o_sat[c])
        );
    end

    assign o_ps_ready  = (state_q == ST_ACCUM);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_acc_valid = valid_q;

endmodule

// File: tb/tb_acc_bias_gen.sv
// Directed bench for acc_bias_gen: default 25-bit instance plus an 18-bit
// instance sharing the stimulus, checked against a bench-side scoreboard.
module tb_acc_bias_gen;

    localparam int COLS = 5;
    localparam int PS   = 16;
    localparam int BB   = 16;
    localparam int AB   = 25;
    localparam int AB18 = 18;
    localparam int CB   = 8;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 i_start;
    logic [CB-1:0]        i_k_len;
    logic [BB*COLS-1:0]   i_bias;
    logic                 i_ps_valid;
    logic [PS*COLS-1:0]   i_ps;
    logic                 i_out_ready;

    logic                 ps_ready, busy, acc_valid;
    logic [AB*COLS-1:0]   acc_bias;
    logic [COLS-1:0]      sat;
    logic                 ps_ready18, busy18, acc_valid18;
    logic [AB18*COLS-1:0] acc_bias18;
    logic [COLS-1:0]      sat18;

    typedef struct {
        logic [127:0]    acc25;
        logic [COLS-1:0] sat25;
        logic [127:0]    acc18;
        logic [COLS-1:0] sat18;
    } exp_t;

    exp_t               exp_q[$];
    logic [PS*COLS-1:0] cur_beats[$];
    int                 checks = 0;
    int                 errors = 0;

    always #5 clk = ~clk;

    acc_bias_gen #(.COLS(COLS), .PS_BW(PS), .BIAS_BW(BB), .AB_BW(AB), .CNT_BW(CB)) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_k_len(i_k_len), .i_bias(i_bias),
        .i_ps_valid(i_ps_valid), .o_ps_ready(ps_ready), .i_ps(i_ps), .o_busy(busy),
        .o_acc_valid(acc_valid), .i_out_ready(i_out_ready), .o_acc_bias(acc_bias), .o_sat(sat)
    );

    acc_bias_gen #(.COLS(COLS), .PS_BW(PS), .BIAS_BW(BB), .AB_BW(AB18), .CNT_BW(CB)) dut18 (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_k_len(i_k_len), .i_bias(i_bias),
        .i_ps_valid(i_ps_valid), .o_ps_ready(ps_ready18), .i_ps(i_ps), .o_busy(busy18),
        .o_acc_valid(acc_valid18), .i_out_ready(i_out_ready), .o_acc_bias(acc_bias18),
        .o_sat(sat18)
    );

    function automatic logic [BB*COLS-1:0] pack5(input int v0, input int v1, input int v2,
                                                 input int v3, input int v4);
        logic [BB*COLS-1:0] r;
        r[0*BB +: BB] = 16'(v0);
        r[1*BB +: BB] = 16'(v1);
        r[2*BB +: BB] = 16'(v2);
        r[3*BB +: BB] = 16'(v3);
        r[4*BB +: BB] = 16'(v4);
        return r;
    endfunction

    // Reference: 64-bit signed accumulate with clamp after every beat.
    function automatic logic [127:0] model(input logic [BB*COLS-1:0] b, input int unsigned bw,
                                           output logic [COLS-1:0] s);
        logic [127:0]       r;
        logic [PS*COLS-1:0] beat;
        logic [63:0]        av;
        longint             a, mx, mn;
        r  = '0;
        s  = '0;
        mx = (64'sd1 <<< (bw - 1)) - 64'sd1;
        mn = -mx - 64'sd1;
        for (int i = 0; i < COLS; i++) begin
            a = longint'($signed(b[i*BB +: BB]));
            foreach (cur_beats[k]) begin
                beat = cur_beats[k];
                a = a + longint'($signed(beat[i*PS +: PS]));
                if (a > mx) begin
                    a = mx;
                    s[i] = 1'b1;
                end else if (a < mn) begin
                    a = mn;
                    s[i] = 1'b1;
                end
            end
            av = a;
            for (int j = 0; j < int'(bw); j++) r[i*int'(bw) + j] = av[j];
        end
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_tile(input logic [BB*COLS-1:0] b, input int k);
        exp_t            e;
        logic [COLS-1:0] s25, s18;
        e.acc25 = model(b, AB, s25);
        e.acc18 = model(b, AB18, s18);
        e.sat25 = s25;
        e.sat18 = s18;
        exp_q.push_back(e);
        i_bias  = b;
        i_k_len = CB'(k);
        i_start = 1'b1;
        tick;
        i_start     = 1'b0;
        i_out_ready = 1'b0;
    endtask

    task automatic feed_beats;
        foreach (cur_beats[k]) begin
            i_ps_valid = 1'b1;
            i_ps       = cur_beats[k];
            tick;
        end
        i_ps_valid = 1'b0;
    endtask

    task automatic check_result(input string tag);
        exp_t e;
        int   n = 0;
        while (!acc_valid && n < 20) begin
            tick;
            n++;
        end
        check({tag, "_latency"}, 128'(n), 128'(0));
        check({tag, "_sb"}, 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check({tag, "_acc25"}, 128'(acc_bias), e.acc25);
            check({tag, "_sat25"}, 128'(sat), 128'(e.sat25));
            check({tag, "_valid18"}, 128'(acc_valid18), 128'(1));
            check({tag, "_acc18"}, 128'(acc_bias18), e.acc18);
            check({tag, "_sat18"}, 128'(sat18), 128'(e.sat18));
        end
    endtask

    task automatic accept(input string tag);
        i_out_ready = 1'b1;
        tick;
        i_out_ready = 1'b0;
        check({tag, "_valid_drop"}, 128'(acc_valid), 128'(0));
    endtask

    initial begin
        rst_n = 1'b0; i_start = 1'b0; i_k_len = '0; i_bias = '0;
        i_ps_valid = 1'b0; i_ps = '0; i_out_ready = 1'b0;
        tick;
        tick;
        check("rst_valid", 128'(acc_valid), 128'(0));
        check("rst_ready", 128'(ps_ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_acc", 128'(acc_bias), 128'(0));
        check("rst_sat", 128'(sat), 128'(0));
        rst_n = 1'b1;
        tick;

        // Test 1: three consecutive beats onto a bias.
        cur_beats = '{pack5(5, 100, -1, 0, -32768), pack5(-3, 200, -1, 0, -32768),
                      pack5(7, -50, -1, 0, -32768)};
        start_tile(pack5(10, -100, 3, 0, 1000), 3);
        check("t1_busy", 128'(busy), 128'(1));
        check("t1_ready", 128'(ps_ready), 128'(1));
        feed_beats;
        check("t1_col0", 128'(acc_bias[AB-1:0]), 128'(19));
        check_result("t1");
        accept("t1");

        // Test 2: positive saturation at 18 bits, other columns untouched.
        cur_beats = '{pack5(32767, 1, 0, -2, 0), pack5(32767, 1, 0, -2, 0),
                      pack5(32767, 1, 0, -2, 0), pack5(32767, 1, 0, -2, 0),
                      pack5(32767, 1, 0, -2, 0)};
        start_tile(pack5(0, 0, 0, 0, 0), 5);
        feed_beats;
        check("t2_col0_18", 128'(acc_bias18[AB18-1:0]), 128'(131071));
        check("t2_sat_18", 128'(sat18), 128'(5'b00001));
        check_result("t2");
        accept("t2");

        // Test 2b: later beats continue from the clamped value, negative clamp too.
        cur_beats = '{pack5(32767, 0, -32768, 0, 0), pack5(32767, 0, -32768, 0, 0),
                      pack5(32767, 0, -32768, 0, 0), pack5(32767, 0, -32768, 0, 0),
                      pack5(32767, 0, -32768, 0, 0), pack5(-1, 0, -32768, 0, 0)};
        start_tile(pack5(0, 0, 0, 0, 0), 6);
        feed_beats;
        check("t2b_col0_18", 128'(acc_bias18[AB18-1:0]), 128'(131070));
        check_result("t2b");
        accept("t2b");

        // Test 3: zero-length tile is bias only; beats offered are ignored.
        cur_beats.delete();
        i_ps_valid = 1'b1;
        i_ps = pack5(111, 222, 333, 444, 555);
        start_tile(pack5(0, -7, 0, 0, 0), 0);
        check("t3_ready", 128'(ps_ready), 128'(0));
        check("t3_col1", 128'(acc_bias[2*AB-1:AB]), 128'(25'h1FFFFF9));
        check_result("t3");
        i_ps_valid = 1'b0;
        accept("t3");

        // Test 4: held result stays stable under back-pressure.
        cur_beats = '{pack5(-20, 4, 9, 1, -1), pack5(6, 4, -9, 1, -1)};
        start_tile(pack5(50, -50, 7, 0, 2), 2);
        feed_beats;
        for (int i = 0; i < 4; i++) begin
            i_ps_valid = 1'b1;
            i_ps = PS*COLS'($urandom());
            tick;
            check("t4_valid", 128'(acc_valid), 128'(1));
            check("t4_ready", 128'(ps_ready), 128'(0));
            check("t4_acc", 128'(acc_bias), exp_q[0].acc25);
        end
        i_ps_valid = 1'b0;
        check_result("t4");
        accept("t4");

        // Test 5: reset mid-tile abandons it.
        cur_beats = '{pack5(1, 1, 1, 1, 1), pack5(1, 1, 1, 1, 1),
                      pack5(1, 1, 1, 1, 1), pack5(1, 1, 1, 1, 1)};
        start_tile(pack5(3, 3, 3, 3, 3), 4);
        for (int i = 0; i < 2; i++) begin
            i_ps_valid = 1'b1;
            i_ps = cur_beats[i];
            tick;
        end
        i_ps_valid = 1'b0;
        void'(exp_q.pop_back());
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        check("t5_valid", 128'(acc_valid), 128'(0));
        check("t5_busy", 128'(busy), 128'(0));
        check("t5_ready", 128'(ps_ready), 128'(0));
        check("t5_acc", 128'(acc_bias), 128'(0));
        check("t5_sat", 128'(sat), 128'(0));
        cur_beats = '{pack5(1, 1, 1, 1, 1), pack5(1, 1, 1, 1, 1)};
        start_tile(pack5(0, 0, 0, 0, 0), 2);
        feed_beats;
        check("t5_col0", 128'(acc_bias[AB-1:0]), 128'(2));
        check_result("t5");
        accept("t5");

        // Test 6: back-to-back tiles through HOLD.
        cur_beats = '{pack5(100, -100, 5, 5, 5), pack5(100, -100, 5, 5, 5)};
        start_tile(pack5(1, 2, 3, 4, 5), 2);
        feed_beats;
        check_result("t6a");
        cur_beats = '{pack5(-9, 8, -7, 6, -5), pack5(4, -3, 2, -1, 0),
                      pack5(32767, -32768, 1, 1, 1)};
        i_out_ready = 1'b1;
        start_tile(pack5(-1000, 1000, 0, -5, 5), 3);
        check("t6b_gap", 128'(acc_valid), 128'(0));
        check("t6b_busy", 128'(busy), 128'(1));
        check("t6b_ready", 128'(ps_ready), 128'(1));
        feed_beats;
        check_result("t6b");
        cur_beats.delete();
        i_out_ready = 1'b1;
        start_tile(pack5(-1, 7, -32768, 32767, 0), 0);
        check("t6c_gap", 128'(acc_valid), 128'(0));
        check("t6c_busy", 128'(busy), 128'(1));
        tick;
        check_result("t6c");
        accept("t6c");
        tick;
        check("end_busy", 128'(busy), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
